// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the unified memory-port arbiter.
package mem_arb_pkg;

    // Sequencer states: one transaction moves through all four in order.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    // Which requester owns the transaction currently on the port.
    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    // Byte-lane count for the default 32-bit data path.
    localparam int DEF_DW    = 32;
    localparam int DEF_BYTES = DEF_DW / 8;

    // Byte-lane count for an arbitrary data width.
    function automatic int bytes_of(input int dw);
        return dw / 8;
    endfunction

    // A data width is usable only if it is a non-zero whole number of bytes.
    function automatic bit dw_ok(input int dw);
        return (dw > 0) && ((dw % 8) == 0);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the unified memory port.
// slave: the arbiter's view. master: the pipeline plus memory driving it.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int BW = bytes_of(DW);

    // Fetch side
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_abort;
    logic [DW-1:0] i_rdata;
    logic          i_valid;
    // Data side
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_wstrb;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    // Stall requests into the hazard unit
    logic          stallF_mem;
    logic          stallM_mem;
    // Memory command and response
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, i_abort,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  mem_rdata,
        output i_rdata, i_valid, d_rdata, d_valid,
        output stallF_mem, stallM_mem,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output i_req, i_addr, i_abort,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output mem_rdata,
        input  i_rdata, i_valid, d_rdata, d_valid,
        input  stallF_mem, stallM_mem,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/arb_lat_timer.sv
// Loadable down-counter that flags the cycle the memory read data is valid.
module arb_lat_timer #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);
    localparam int CW = $clog2(MEM_LAT + 1);

    logic [CW-1:0] count_q, count_d;

    // Load takes precedence; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CW'(MEM_LAT);
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            count_q <= count_d;
        end
    end

    // Read data is on mem_rdata in the cycle the count sits at 1.
    assign done_o = (count_q == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the memory port shared by fetch and memory stages.
// One transaction at a time; data has priority over fetch.
// Optional build macro MEM_ARB_STARVE_GUARD_EN bounds consecutive data grants
// while a fetch waits (STARVE_MAX); without it, data priority is strict.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int BW = bytes_of(DW);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          txn_we_q, txn_we_d;
    logic          kill_q, kill_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [BW-1:0] mem_wstrb_q, mem_wstrb_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_valid_q, i_valid_d;
    logic          d_valid_q, d_valid_d;
    logic          tmr_load, tmr_dec, tmr_done;
    logic          force_i, grant_d, grant_i, abort_hit;

    arb_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .dec_i  (tmr_dec),
        .done_o (tmr_done)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign force_i = (starve_q == SW'(STARVE_MAX));

    // Count data grants that bypassed a waiting fetch; any fetch grant resets.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (grant_i) begin
                starve_d = '0;
            end else if (grant_d && bus.i_req && !force_i) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    // Arbitration: data wins unless the guard is forcing a fetch through.
    assign grant_d   = bus.d_req && !(force_i && bus.i_req && !bus.i_abort);
    assign grant_i   = !grant_d && bus.i_req && !bus.i_abort;
    assign abort_hit = (owner_q == OWN_I) && bus.i_abort;

    // Next-state, command latch, response capture and valid generation.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        txn_we_d    = txn_we_q;
        kill_d      = kill_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (grant_d) begin
                    owner_d     = OWN_D;
                    txn_we_d    = bus.d_we;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_wstrb_d = bus.d_we ? bus.d_wstrb : '0;
                    state_d     = ISSUE;
                end else if (grant_i) begin
                    owner_d    = OWN_I;
                    txn_we_d   = 1'b0;
                    mem_addr_d = bus.i_addr;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                tmr_load = 1'b1;
                state_d  = WAIT;
                if (abort_hit) kill_d = 1'b1;
            end
            WAIT: begin
                tmr_dec = 1'b1;
                if (abort_hit) kill_d = 1'b1;
                if (tmr_done) begin
                    state_d = RESP;
                    if (owner_q == OWN_I) begin
                        if (!(kill_q || abort_hit)) begin
                            i_rdata_d = bus.mem_rdata;
                            i_valid_d = 1'b1;
                        end
                    end else begin
                        if (!txn_we_q) d_rdata_d = bus.mem_rdata;
                        d_valid_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                if (abort_hit) kill_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            txn_we_q    <= 1'b0;
            kill_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            txn_we_q    <= txn_we_d;
            kill_q      <= kill_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_valid_q   <= i_valid_d;
            d_valid_q   <= d_valid_d;
        end
    end

    // The strobe is a decode of the state flop; command fields are zero
    // outside ISSUE because they are only loaded on the grant edge.
    assign bus.mem_req    = (state_q == ISSUE);
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wstrb  = mem_wstrb_q;
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.i_valid    = i_valid_q;
    assign bus.d_valid    = d_valid_q;
    assign bus.stallF_mem = bus.i_req & ~i_valid_q & ~bus.i_abort;
    assign bus.stallM_mem = bus.d_req & ~d_valid_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single unified memory port shared by the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage core. It serialises one transaction at a time onto a fixed-latency memory, returns read data with a one-cycle valid pulse, and generates memory-side stall requests that are OR'd into the pipeline stall/flush logic alongside load-use and branch hazards. Data accesses have priority over fetches, optionally bounded by a starvation guard.

## Interface
- AW, 32, address width
- DW, 32, data width; must be a multiple of 8
- MEM_LAT, 2, cycles from the `mem_req` cycle to the cycle `mem_rdata` is valid; must be ≥1
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending (guard builds only)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; level, held until `i_valid` or abort
- i_addr  in  AW  fetch address
- i_abort  in  1  discard any pending or in-flight fetch (redirect flush)
- i_rdata  out  DW  fetched instruction, registered
- i_valid  out  1  one-cycle pulse: `i_rdata` valid
- d_req  in  1  data request; level, held until `d_valid`
- d_we  in  1  1 = store
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_wstrb  in  DW/8  store byte enables
- d_rdata  out  DW  load data, registered
- d_valid  out  1  one-cycle pulse: data access complete
- stallF_mem  out  1  `i_req & ~i_valid & ~i_abort`, combinational
- stallM_mem  out  1  `d_req & ~d_valid`, combinational
- mem_req  out  1  one-cycle issue strobe
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/AW/DW/DW/8  registered command fields
- mem_rdata  in  DW  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if `d_req`, grant D. Otherwise, if `i_req & ~i_abort`, grant I. If neither, stay. On grant, latch owner, address, we, wdata, and wstrb, then go to ISSUE.
- I grants force `we=0` and `wstrb=0`. D loads force `wstrb=0`.
- ISSUE: `mem_req=1` with the latched fields for exactly one cycle. Then go to WAIT, with the latency counter loaded to MEM_LAT.
- WAIT: decrement the counter. When the counter reaches 1, capture `mem_rdata` into the owner's rdata register, then go to RESP.
  - Stores do not capture; `d_rdata` holds its previous value.
- RESP: pulse the owner's valid for one cycle, then go to IDLE. Requests are ignored during RESP.
- Abort: `i_abort` asserted in any cycle while owner=I (ISSUE, WAIT, or RESP) sets a kill flag.
  - The transaction completes on the memory, but `i_valid` is suppressed and `i_rdata` is not updated.
  - The kill flag clears in IDLE.
  - In IDLE, `i_abort` blocks an I grant that cycle; a D grant is unaffected.
- Owner state is never visible on the memory bus outside the ISSUE cycle. `mem_req=0` in all other states.

## Timing
- Read latency, request to valid: MEM_LAT+2 cycles. The port is busy MEM_LAT+3 cycles per transaction; at most one transaction is outstanding.
- Simultaneous `i_req` and `d_req` in IDLE: D wins. I is granted in the IDLE that follows D's RESP.
- Reset values: all registered outputs are 0, including `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `i_rdata`, `d_rdata`, `i_valid`, and `d_valid`. State is IDLE and the counter and kill flag are 0.
- Reset mid-transaction: abandoned immediately with no valid pulse after release. The memory must tolerate a dropped read.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: a counter increments on each D grant made while `i_req` is high, and clears on every I grant.
  - When the counter equals STARVE_MAX, the next IDLE arbitration grants I even if `d_req` is high, provided there is no `i_abort`.
- Undefined: strict D priority. The counter and STARVE_MAX are unused.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum: IDLE, ISSUE, WAIT, RESP
  - owner enum: OWN_I, OWN_D
  - width-check constants derived from DW: byte count = DW/8
- Sub-module `arb_lat_timer`: loadable down-counter with a `done` output, sized `$clog2(MEM_LAT+1)`.

## Test plan
- Fetch, MEM_LAT=2, `i_req`@0 with addr 0x100 → `mem_req`=1 @1 with `mem_addr`=0x100. Memory drives 0x00500093 @3. `i_valid`@4 with `i_rdata`=0x00500093. `stallF_mem` high @0–3.
- `i_req` and `d_req` (load 0x2000) both @0 → D issued @1, `d_valid`@4. I granted @5, `mem_req`@6, `i_valid`@9.
- Store @0 with `d_we`=1, addr 0x2004, wdata 0xDEADBEEF, wstrb 0b0011 → @1 `mem_we`=1 and `mem_wstrb`=0b0011. `d_valid`@4. `d_rdata` unchanged.
- Fetch @0, `i_abort` pulsed @2 → no `i_valid`, `i_rdata` unchanged, IDLE @5. New `i_req` to 0x200 @5 → `i_valid`@9.
- Guard build, STARVE_MAX=2: `i_req` held, `d_req` re-asserted every IDLE → two D grants, then I granted on the third arbitration. In a non-guard build, I is never granted while `d_req` is continuously asserted.
- `rst_n` low during WAIT → all outputs 0 asynchronously. After release: IDLE, no stray valid; a fresh request completes with normal latency.
